// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: issues pc_i to instruction memory, buffers {pc, instr}
// in a small FIFO toward decode, and stalls the PC register until a fetch is granted.
module if_fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  output logic        stop_o,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o,
  input  logic        id_ready_i
);

  // state  | meaning
  // S_IDLE | nothing outstanding
  // S_WAIT | one fetch outstanding, its response will be pushed
  // S_DROP | one fetch outstanding, its response will be discarded
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [31:0]     r_out_pc;
  logic [31:0]     r_fifo_pc    [DEPTH];
  logic [31:0]     r_fifo_instr [DEPTH];

  logic            w_req;
  logic            w_grant;
  logic            w_push;
  logic            w_pop;
  logic            w_valid;
  logic [CW:0]     w_occ;

  assign w_valid = (r_count != '0);
  // Registered occupancy plus the slot reserved by a kept in-flight response.
  assign w_occ   = {1'b0, r_count} + {{CW{1'b0}}, (r_state == S_WAIT)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          if (flush_i)      w_state_nxt = S_IDLE;
          else if (w_grant) w_state_nxt = S_WAIT;
          else              w_state_nxt = S_IDLE;
        end else if (flush_i) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid_i) w_state_nxt = w_grant ? S_WAIT : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_req   = 1'b0;
    w_grant = 1'b0;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_req   = rst_n && !flush_i && ((r_state == S_IDLE) || imem_rvalid_i) && (w_occ < DEPTH_C);
    w_grant = w_req && imem_gnt_i;
    w_push  = (r_state == S_WAIT) && imem_rvalid_i && !flush_i;
    w_pop   = w_valid && id_ready_i && !flush_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_pc <= '0;
    end else if (w_grant) begin
      r_out_pc <= pc_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_pc[i]    <= '0;
        r_fifo_instr[i] <= '0;
      end
    end else if (flush_i) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_wptr]    <= r_out_pc;
        r_fifo_instr[r_wptr] <= imem_rdata_i;
        r_wptr               <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (r_count == CW'(DEPTH))));

  assign imem_req_o  = w_req;
  assign imem_addr_o = pc_i;
  assign stop_o      = !(w_grant || flush_i);
  assign id_valid_o  = w_valid;
  assign id_pc_o     = r_fifo_pc[r_rptr];
  assign id_instr_o  = r_fifo_instr[r_rptr];

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a PC-register model and a
// fixed-latency instruction memory model.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_i;
  logic        stop_o;
  logic        flush_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;
  logic        id_ready_i;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat      = 1;
  int          cnt      = 0;
  bit          pend     = 1'b0;
  bit          ovr      = 1'b0;
  logic [31:0] paddr    = '0;
  logic [31:0] flush_tgt = '0;

  if_fetch_queue #(.DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_i          (pc_i),
    .stop_o        (stop_o),
    .flush_i       (flush_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .id_valid_o    (id_valid_o),
    .id_pc_o       (id_pc_o),
    .id_instr_o    (id_instr_o),
    .id_ready_i    (id_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {16'h0513, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic chk_fetch(input string tag, input logic req, input logic [31:0] addr, input logic stp);
    check({tag, "_req"}, {31'd0, imem_req_o}, {31'd0, req});
    if (req) check({tag, "_addr"}, imem_addr_o, addr);
    check({tag, "_stop"}, {31'd0, stop_o}, {31'd0, stp});
  endtask

  task automatic chk_head(input string tag, input logic vld, input logic [31:0] pc);
    check({tag, "_valid"}, {31'd0, id_valid_o}, {31'd0, vld});
    if (vld) begin
      check({tag, "_pc"}, id_pc_o, pc);
      check({tag, "_instr"}, id_instr_o, instr_of(pc));
    end
  endtask

  // One clock: PC register and memory models react to what was seen before the edge.
  task automatic tick();
    logic        g;
    logic        st;
    logic        fl;
    logic [31:0] a;
    g  = imem_req_o && imem_gnt_i;
    st = stop_o;
    fl = flush_i;
    a  = imem_addr_o;
    @(posedge clk);
    #1;
    if (fl)       pc_i = flush_tgt;
    else if (!st) pc_i = pc_i + 32'd4;
    imem_rvalid_i = 1'b0;
    if (g) begin
      pend  = 1'b1;
      cnt   = lat;
      paddr = a;
    end
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        pend          = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = ovr ? 32'hDEADBEEF : instr_of(paddr);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; pc_i = 32'h0; flush_i = 1'b0; imem_gnt_i = 1'b1;
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; id_ready_i = 1'b1;
    #1;
    check("rst_valid", {31'd0, id_valid_o}, 32'd0);
    check("rst_pc", id_pc_o, 32'h0);
    check("rst_instr", id_instr_o, 32'h0);
    check("rst_req", {31'd0, imem_req_o}, 32'd0);
    check("rst_stop", {31'd0, stop_o}, 32'd1);
    tick(); tick();

    // Streaming with k=1, decode ready
    rst_n = 1'b1; #1;
    chk_fetch("c1", 1'b1, 32'h0, 1'b0);  chk_head("c1", 1'b0, 32'h0);  tick();
    #1; chk_fetch("c2", 1'b1, 32'h4, 1'b0);  chk_head("c2", 1'b0, 32'h0);  tick();
    #1; chk_fetch("c3", 1'b0, 32'h0, 1'b1);  chk_head("c3", 1'b1, 32'h0);  tick();
    #1; chk_fetch("c4", 1'b1, 32'h8, 1'b0);  chk_head("c4", 1'b1, 32'h4);  tick();
    #1; chk_fetch("c5", 1'b1, 32'hC, 1'b0);  chk_head("c5", 1'b0, 32'h0);  tick();
    #1; chk_fetch("c6", 1'b0, 32'h0, 1'b1);  chk_head("c6", 1'b1, 32'h8);  tick();

    // Back-pressure: FIFO fills, no requests while full
    id_ready_i = 1'b0; #1;
    chk_fetch("c7", 1'b1, 32'h10, 1'b0); chk_head("c7", 1'b1, 32'hC);  tick();
    #1; chk_fetch("c8", 1'b0, 32'h0, 1'b1);  chk_head("c8", 1'b1, 32'hC);  tick();
    #1; chk_fetch("c9", 1'b0, 32'h0, 1'b1);  tick();
    #1; chk_fetch("c10", 1'b0, 32'h0, 1'b1); chk_head("c10", 1'b1, 32'hC); tick();
    id_ready_i = 1'b1; #1;
    chk_fetch("c11", 1'b0, 32'h0, 1'b1); chk_head("c11", 1'b1, 32'hC); tick();

    // Grant delay: one request after the pop, held for three cycles
    id_ready_i = 1'b0; imem_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; chk_fetch($sformatf("gd%0d", i), 1'b1, 32'h14, 1'b1);
      chk_head($sformatf("gd%0d", i), 1'b1, 32'h10);
      tick();
    end
    imem_gnt_i = 1'b1; id_ready_i = 1'b1; #1;
    chk_fetch("c15", 1'b1, 32'h14, 1'b0); tick();

    // Flush while a fetch is in flight; its late response must be dropped
    lat = 3; ovr = 1'b1; #1;
    chk_fetch("c16", 1'b1, 32'h18, 1'b0); chk_head("c16", 1'b0, 32'h0); tick();
    flush_i = 1'b1; flush_tgt = 32'h100; #1;
    check("c17_req", {31'd0, imem_req_o}, 32'd0);
    check("c17_stop", {31'd0, stop_o}, 32'd0);
    chk_head("c17", 1'b1, 32'h14); tick();
    flush_i = 1'b0; #1;
    chk_fetch("c18", 1'b0, 32'h0, 1'b1); chk_head("c18", 1'b0, 32'h0); tick();
    lat = 1; ovr = 1'b0; #1;
    check("c19_rvalid", {31'd0, imem_rvalid_i}, 32'd1);
    chk_fetch("c19", 1'b1, 32'h100, 1'b0); chk_head("c19", 1'b0, 32'h0); tick();
    #1; chk_fetch("c20", 1'b1, 32'h104, 1'b0); chk_head("c20", 1'b0, 32'h0); tick();

    // Flush coincident with a response in WAIT
    flush_i = 1'b1; flush_tgt = 32'h200; #1;
    check("c21_rvalid", {31'd0, imem_rvalid_i}, 32'd1);
    chk_fetch("c21", 1'b0, 32'h0, 1'b0); chk_head("c21", 1'b1, 32'h100); tick();
    flush_i = 1'b0; #1;
    chk_fetch("c22", 1'b1, 32'h200, 1'b0); chk_head("c22", 1'b0, 32'h0); tick();

    // Reset while a fetch is outstanding with an entry queued
    lat = 3; id_ready_i = 1'b0; #1;
    chk_fetch("c23", 1'b1, 32'h204, 1'b0); chk_head("c23", 1'b0, 32'h0); tick();
    #1; chk_fetch("c24", 1'b0, 32'h0, 1'b1); chk_head("c24", 1'b1, 32'h200); tick();
    rst_n = 1'b0; #1;
    check("mrst_valid", {31'd0, id_valid_o}, 32'd0);
    check("mrst_pc", id_pc_o, 32'h0);
    check("mrst_instr", id_instr_o, 32'h0);
    check("mrst_req", {31'd0, imem_req_o}, 32'd0);
    check("mrst_stop", {31'd0, stop_o}, 32'd1);
    tick();
    rst_n = 1'b1; imem_gnt_i = 1'b0; #1;
    check("c26_stale_rvalid", {31'd0, imem_rvalid_i}, 32'd1);
    chk_fetch("c26", 1'b1, 32'h208, 1'b1); chk_head("c26", 1'b0, 32'h0); tick();
    #1; chk_head("c27", 1'b0, 32'h0);
    chk_fetch("c27", 1'b1, 32'h208, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
